// File: rtl/link_serializer.sv
// ---------------------------------------------------------------------------
// link_serializer
//
// Converts one parallel flit from the routing logic into a serial frame:
//   start bit (1), FLIT_W data bits LSB first, optional even-parity bit.
// A flit is captured on acceptance and held until the frame has gone out.
// Downstream backpressure (channel_busy) only delays the start of a frame.
// Once the start bit is on the wire the frame always runs to completion.
//
// Optional feature macro: LINK_PARITY_EN. When defined, an even-parity bit
// (XOR of all flit bits) is appended after the data bits.
//
// Ports:
//   clk          - router clock, rising edge
//   reset        - asynchronous, active-high
//   req          - flit-transfer request from routing logic
//   parallel_in  - flit, valid while req=1
//   tx_busy      - high from acceptance until the frame has ended
//   channel_busy - receiver backpressure, sampled only while waiting to start
//   serial_out   - registered serial line, 0 when idle
//   tx_active    - high from the start bit through the last frame bit
//   sent_count   - completed frames, 16-bit wrapping
// ---------------------------------------------------------------------------

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 4
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

module link_serializer #(
    parameter int FLIT_W = (`HDR_SZ + `PL_SZ + `ADDR_SZ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [FLIT_W-1:0] parallel_in,
    output logic              tx_busy,
    input  logic              channel_busy,
    output logic              serial_out,
    output logic              tx_active,
    output logic [15:0]       sent_count
);

    // Counter must be able to hold FLIT_W itself: it counts bits already driven.
    localparam int CNT_W = $clog2(FLIT_W + 1);

`ifdef LINK_PARITY_EN
    typedef enum logic [1:0] {IDLE, ARB, DATA, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ARB, DATA} state_t;
`endif

    state_t             state;
    logic [FLIT_W-1:0]  shreg;
    logic [CNT_W-1:0]   bit_cnt;

`ifdef LINK_PARITY_EN
    logic               parity_bit;

    // Even parity: the appended bit makes the total count of ones even.
    function automatic logic even_parity(input logic [FLIT_W-1:0] flit);
        return ^flit;
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            serial_out <= 1'b0;
            tx_active  <= 1'b0;
            tx_busy    <= 1'b0;
            sent_count <= 16'd0;
            shreg      <= '0;
            bit_cnt    <= '0;
`ifdef LINK_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= 1'b0;
                    // Registered tx_busy gates acceptance, so a req at the
                    // edge where tx_busy falls cannot be taken.
                    if (req && !tx_busy) begin
                        shreg   <= parallel_in;
                        tx_busy <= 1'b1;
                        state   <= ARB;
`ifdef LINK_PARITY_EN
                        parity_bit <= even_parity(parallel_in);
`endif
                    end
                end

                ARB: begin
                    if (channel_busy) begin
                        serial_out <= 1'b0;
                    end else begin
                        serial_out <= 1'b1;   // start bit
                        tx_active  <= 1'b1;
                        bit_cnt    <= '0;
                        state      <= DATA;
                    end
                end

                DATA: begin
                    if (bit_cnt == CNT_W'(FLIT_W)) begin
`ifdef LINK_PARITY_EN
                        serial_out <= parity_bit;
                        state      <= PAR;
`else
                        serial_out <= 1'b0;
                        tx_active  <= 1'b0;
                        tx_busy    <= 1'b0;
                        sent_count <= sent_count + 16'd1;
                        state      <= IDLE;
`endif
                    end else begin
                        serial_out <= shreg[0];
                        shreg      <= shreg >> 1;
                        bit_cnt    <= bit_cnt + CNT_W'(1);
                    end
                end

`ifdef LINK_PARITY_EN
                PAR: begin
                    serial_out <= 1'b0;
                    tx_active  <= 1'b0;
                    tx_busy    <= 1'b0;
                    sent_count <= sent_count + 16'd1;
                    state      <= IDLE;
                end
`endif

                default: begin
                    serial_out <= 1'b0;
                    tx_active  <= 1'b0;
                    tx_busy    <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for link_serializer (FLIT_W = 8). The reference model builds the
// expected frame as a bit list straight from the framing rules and tracks
// the expected completed-frame count.
// ---------------------------------------------------------------------------
module tb_link_serializer;

    localparam int W = 8;
`ifdef LINK_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic [W-1:0] parallel_in = '0;
    logic         tx_busy;
    logic         channel_busy = 1'b0;
    logic         serial_out;
    logic         tx_active;
    logic [15:0]  sent_count;

    int           checks = 0;
    int           failures = 0;
    logic [15:0]  exp_count = 16'd0;

    link_serializer #(.FLIT_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .parallel_in  (parallel_in),
        .tx_busy      (tx_busy),
        .channel_busy (channel_busy),
        .serial_out   (serial_out),
        .tx_active    (tx_active),
        .sent_count   (sent_count)
    );

    always #5 clk = ~clk;

    // Present one flit, hold off the start for busy_cyc cycles, then follow
    // the frame bit by bit against the model's expected bit list.
    task automatic send_frame(input string name, input logic [W-1:0] flit,
                              input int busy_cyc, input bit toggle, input bit keep_req);
        bit exp_bits[$];
        int guard;
        exp_bits.push_back(1'b1);
        for (int i = 0; i < W; i++) exp_bits.push_back(flit[i]);
        if (PAR_EN) begin
            bit p = 1'b0;
            for (int i = 0; i < W; i++) p = p ^ flit[i];
            exp_bits.push_back(p);
        end

        @(negedge clk);
        guard = 0;
        while (tx_busy !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (tx_busy !== 1'b0) begin
            checks++; failures++;
            $display("FAIL %s idle_timeout tx_busy=%b required 0", name, tx_busy);
            return;
        end

        req = 1'b1;
        parallel_in = flit;
        channel_busy = (busy_cyc > 0);
        @(posedge clk); #1;
        if (keep_req) parallel_in = W'($urandom); else req = 1'b0;
        checks++;
        if (tx_busy !== 1'b1 || serial_out !== 1'b0 || tx_active !== 1'b0) begin
            failures++;
            $display("FAIL %s accept busy=%b ser=%b act=%b required 1,0,0", name, tx_busy, serial_out, tx_active);
        end

        for (int k = 1; k <= busy_cyc; k++) begin
            @(posedge clk); #1;
            checks++;
            if (serial_out !== 1'b0 || tx_active !== 1'b0 || tx_busy !== 1'b1) begin
                failures++;
                $display("FAIL %s arb_wait%0d ser=%b act=%b busy=%b required 0,0,1", name, k, serial_out, tx_active, tx_busy);
            end
            if (keep_req) parallel_in = W'($urandom);
        end
        channel_busy = 1'b0;

        for (int i = 0; i < exp_bits.size(); i++) begin
            @(posedge clk); #1;
            checks++;
            if (serial_out !== exp_bits[i] || tx_active !== 1'b1 || tx_busy !== 1'b1) begin
                failures++;
                $display("FAIL %s bit%0d ser=%b act=%b busy=%b required %b,1,1", name, i, serial_out, tx_active, tx_busy, exp_bits[i]);
            end
            if (toggle) channel_busy = 1'($urandom);
            if (keep_req) parallel_in = W'($urandom);
        end

        @(posedge clk); #1;
        exp_count = exp_count + 16'd1;
        checks++;
        if (serial_out !== 1'b0 || tx_active !== 1'b0 || tx_busy !== 1'b0 || sent_count !== exp_count) begin
            failures++;
            $display("FAIL %s frame_end ser=%b act=%b busy=%b cnt=%h required 0,0,0,%h", name, serial_out, tx_active, tx_busy, sent_count, exp_count);
        end
        req = 1'b0;
        channel_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (serial_out !== 1'b0 || tx_active !== 1'b0 || tx_busy !== 1'b0 || sent_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state ser=%b act=%b busy=%b cnt=%h required 0,0,0,0000", serial_out, tx_active, tx_busy, sent_count);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_count = 16'd0;
    endtask

    task automatic test_basic();
        send_frame("basic_a5", 8'hA5, 0, 1'b0, 1'b0);
        checks++;
        if (sent_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_count got=%h required 0001", sent_count);
        end
    endtask

    task automatic test_channel_busy();
        send_frame("chan_busy5", 8'h5A, 5, 1'b0, 1'b0);
    endtask

    task automatic test_midframe_busy();
        send_frame("mid_toggle", 8'hC3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        // req stays high with changing data through the frame and at the
        // edge tx_busy falls; the held flit must go out unchanged.
        send_frame("req_held", 8'h96, 0, 1'b0, 1'b1);
        send_frame("b2b_next", 8'h69, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            send_frame("random", W'($urandom), int'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom));
        end
    endtask

`ifdef LINK_PARITY_EN
    task automatic test_parity();
        send_frame("parity_07", 8'h07, 0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_reset_midframe();
        @(negedge clk);
        req = 1'b1;
        parallel_in = 8'hFF;
        channel_busy = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (serial_out !== 1'b1 || tx_active !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_bit4 ser=%b act=%b required 1,1", serial_out, tx_active);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (serial_out !== 1'b0 || tx_active !== 1'b0 || tx_busy !== 1'b0 || sent_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_midframe ser=%b act=%b busy=%b cnt=%h required 0,0,0,0000", serial_out, tx_active, tx_busy, sent_count);
        end
        #1;
        reset = 1'b0;
        exp_count = 16'd0;
        send_frame("after_reset_3c", 8'h3C, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_arb();
        @(negedge clk);
        req = 1'b1;
        parallel_in = 8'hE7;
        channel_busy = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        channel_busy = 1'b0;
        exp_count = 16'd0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            checks++;
            if (serial_out !== 1'b0 || tx_busy !== 1'b0 || tx_active !== 1'b0) begin
                failures++;
                $display("FAIL reset_arb_quiet%0d ser=%b busy=%b act=%b required 0,0,0", k, serial_out, tx_busy, tx_active);
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.sent_count = 16'hFFFF;
        #1;
        release dut.sent_count;
        exp_count = 16'hFFFF;
        checks++;
        if (sent_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload got=%h required ffff", sent_count);
        end
        send_frame("wrap", W'($urandom), 0, 1'b0, 1'b0);
        checks++;
        if (sent_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero got=%h required 0000", sent_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_channel_busy();
        test_midframe_busy();
        test_back_to_back();
        test_random();
`ifdef LINK_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        test_reset_arb();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
